// File: rtl/i2s_audio_tx_pkg.sv
// Shared definitions for the mixer-to-I2S transmit path.
package i2s_audio_tx_pkg;

    localparam int I2S_WORD_BITS  = 16;
    localparam int I2S_FRAME_BITS = 32;
    localparam int MIX_SUM_BITS   = 10;
    localparam int MIX_IN_BITS    = 9;
    localparam int BIT_IDX_BITS   = $clog2(I2S_FRAME_BITS);

    typedef struct packed {
        logic [I2S_WORD_BITS-1:0] left;
        logic [I2S_WORD_BITS-1:0] right;
    } i2s_frame_t;

    // Offset-binary mixer sum to two's complement; mid-scale 0x200 becomes 0x0000.
    function automatic logic [I2S_WORD_BITS-1:0] to_i2s_word(input logic [MIX_SUM_BITS-1:0] sum);
        return {~sum[9], sum[8:0], 6'b000000};
    endfunction

endpackage

// File: rtl/i2s_audio_tx_if.sv
// Mixer sample inputs and I2S serial outputs of the transmitter.
interface i2s_audio_tx_if;
    import i2s_audio_tx_pkg::*;

    logic [MIX_IN_BITS-1:0] audio_in_left;
    logic [MIX_IN_BITS-1:0] audio_in_right;
    logic                   i2s_bclk;
    logic                   i2s_lrclk;
    logic                   i2s_sdata;
    logic                   sample_strobe;

    modport master (
        input  audio_in_left, audio_in_right,
        output i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe
    );

    modport slave (
        output audio_in_left, audio_in_right,
        input  i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe
    );

endinterface

// File: rtl/i2s_audio_tx_pair_sum.sv
// Folds the mixer's alternating AY / beeper phases into one sum per Clk.
module i2s_pair_sum
    import i2s_audio_tx_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [MIX_IN_BITS-1:0]  audio_i,
    output logic [MIX_SUM_BITS-1:0] sum_o
);

    logic [MIX_IN_BITS-1:0]  prev_q, prev_d;
    logic [MIX_SUM_BITS-1:0] sum_q, sum_d;

    always_comb begin
        prev_d = audio_i;
        sum_d  = {1'b0, audio_i} + {1'b0, prev_q};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_q <= '0;
            sum_q  <= '0;
        end else begin
            prev_q <= prev_d;
            sum_q  <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S stereo transmitter for the parallel mixer outputs; all timing from Clk.
module i2s_audio_tx
    import i2s_audio_tx_pkg::*;
#(
    parameter int BCLK_DIV = 8
)(
    input  logic           Clk,
    input  logic           Reset,
    i2s_audio_tx_if.master aud
);

    localparam int                DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_TC = DIV_W'(BCLK_DIV - 1);

    logic [MIX_SUM_BITS-1:0] sum_l, sum_r;

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic                    bclk_q, bclk_d;
    logic [BIT_IDX_BITS-1:0] k_q, k_d;
    i2s_frame_t              frame_q, frame_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic                    strobe_q, strobe_d;
    logic                    fall;

    i2s_pair_sum u_sum_left (
        .Clk   (Clk),
        .Reset (Reset),
        .audio_i (aud.audio_in_left),
        .sum_o (sum_l)
    );

    i2s_pair_sum u_sum_right (
        .Clk   (Clk),
        .Reset (Reset),
        .audio_i (aud.audio_in_right),
        .sum_o (sum_r)
    );

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        bclk_d    = bclk_q;
        k_d       = k_q;
        frame_d   = frame_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        strobe_d  = 1'b0;
        fall      = 1'b0;

        if (div_cnt_q == DIV_TC) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            fall      = bclk_q;
        end

        // Serial outputs move only on BCLK falling edges, so they are settled for the codec's rising-edge sample.
        if (fall) begin
            k_d = k_q + BIT_IDX_BITS'(1);
            if (k_q == BIT_IDX_BITS'(I2S_FRAME_BITS - 1)) begin
                frame_d  = '{left: to_i2s_word(sum_l), right: to_i2s_word(sum_r)};
                strobe_d = 1'b1;
            end
            sdata_d = frame_d[BIT_IDX_BITS'(I2S_FRAME_BITS - 1) - k_d];
            lrclk_d = (k_d >= BIT_IDX_BITS'(15)) && (k_d <= BIT_IDX_BITS'(30));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            k_q       <= BIT_IDX_BITS'(I2S_FRAME_BITS - 1);
            frame_q   <= '0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            k_q       <= k_d;
            frame_q   <= frame_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            strobe_q  <= strobe_d;
        end
    end

    assign aud.i2s_bclk      = bclk_q;
    assign aud.i2s_lrclk     = lrclk_q;
    assign aud.i2s_sdata     = sdata_q;
    assign aud.sample_strobe = strobe_q;

endmodule
